// File: rtl/alu_operand_stage.sv
// Operand stage between decode and the ALU: 2-entry in-order skid buffer with
// writeback forwarding at capture and snooping of buffered operands.
module alu_operand_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned FUNC_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      flush_i,
  // Decode side
  input  logic                      dec_valid_i,
  output logic                      dec_ready_o,
  input  logic [FUNC_WIDTH-1:0]     dec_func_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_addr_i,
  input  logic [DATA_WIDTH-1:0]     dec_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     dec_rs2_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd_addr_i,
  // Writeback snoop
  input  logic                      wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     wb_rd_data_i,
  // ALU side
  output logic                      alu_valid_o,
  input  logic                      alu_ready_i,
  output logic [DATA_WIDTH-1:0]     rs1_data_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_o,
  output logic [FUNC_WIDTH-1:0]     func_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  typedef struct packed {
    logic [FUNC_WIDTH-1:0]     func;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
  } entry_t;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_head;
  logic   r_tail;
  logic   w_head_nxt;
  logic   w_tail_nxt;
  entry_t r_entry     [2];
  entry_t w_entry_nxt [2];
  entry_t w_capture;
  entry_t w_head_entry;
  logic   w_push;
  logic   w_pop;
  logic   w_wb_live;
  logic [1:0] w_occ;

  // Handshake outputs come from registered state only, isolating decode from ALU stalls.
  assign dec_ready_o = (r_state != StFull);
  assign alu_valid_o = (r_state != StEmpty);
  assign w_push      = dec_valid_i & dec_ready_o;
  assign w_pop       = alu_valid_o & alu_ready_i;
  assign w_wb_live   = wb_valid_i & (wb_rd_addr_i != '0);

  always_comb begin
    w_capture.func     = dec_func_i;
    w_capture.rs1_addr = dec_rs1_addr_i;
    w_capture.rs2_addr = dec_rs2_addr_i;
    w_capture.rd_addr  = dec_rd_addr_i;
    w_capture.rs1_data = (w_wb_live && (wb_rd_addr_i == dec_rs1_addr_i)) ? wb_rd_data_i
                                                                          : dec_rs1_data_i;
    w_capture.rs2_data = (w_wb_live && (wb_rd_addr_i == dec_rs2_addr_i)) ? wb_rd_data_i
                                                                          : dec_rs2_data_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: if (w_push) w_state_nxt = StOne;
        StOne: begin
          if (w_push && !w_pop) begin
            w_state_nxt = StFull;
          end else if (w_pop && !w_push) begin
            w_state_nxt = StEmpty;
          end
        end
        StFull:  if (w_pop) w_state_nxt = StOne;
        default: w_state_nxt = StEmpty;
      endcase
    end
  end

  assign w_head_nxt = flush_i ? 1'b0 : (r_head ^ w_pop);
  assign w_tail_nxt = flush_i ? 1'b0 : (r_tail ^ w_push);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_occ[i] = (r_state == StFull) || ((r_state == StOne) && (r_head == 1'(i)));
    end
  end

  // A newly pushed entry always lands in an unoccupied slot, so snoop and capture never collide.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_entry_nxt[i] = r_entry[i];
      if (w_occ[i] && !(w_pop && (r_head == 1'(i)))) begin
        if (w_wb_live && (wb_rd_addr_i == r_entry[i].rs1_addr)) begin
          w_entry_nxt[i].rs1_data = wb_rd_data_i;
        end
        if (w_wb_live && (wb_rd_addr_i == r_entry[i].rs2_addr)) begin
          w_entry_nxt[i].rs2_data = wb_rd_data_i;
        end
      end
    end
    if (w_push && !flush_i) begin
      w_entry_nxt[r_tail] = w_capture;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= StEmpty;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      for (int i = 0; i < 2; i++) begin
        r_entry[i] <= w_entry_nxt[i];
      end
    end
  end

  assign w_head_entry = r_entry[r_head];
  assign rs1_data_o   = alu_valid_o ? w_head_entry.rs1_data : '0;
  assign rs2_data_o   = alu_valid_o ? w_head_entry.rs2_data : '0;
  assign func_o       = alu_valid_o ? w_head_entry.func     : '0;
  assign rd_addr_o    = alu_valid_o ? w_head_entry.rd_addr  : '0;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed pushes enqueue expected bundles,
// a negedge monitor checks every bundle the ALU consumes.
module tb_alu_operand_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned FW = 16;
  localparam logic [FW-1:0] SLL  = 16'h0001;
  localparam logic [FW-1:0] SLLI = 16'h0002;
  localparam logic [FW-1:0] SRL  = 16'h0004;

  typedef struct {
    logic [FW-1:0] func;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [AW-1:0] rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst;
  logic          flush_i;
  logic          dec_valid_i;
  logic          dec_ready_o;
  logic [FW-1:0] dec_func_i;
  logic [AW-1:0] dec_rs1_addr_i;
  logic [AW-1:0] dec_rs2_addr_i;
  logic [DW-1:0] dec_rs1_data_i;
  logic [DW-1:0] dec_rs2_data_i;
  logic [AW-1:0] dec_rd_addr_i;
  logic          wb_valid_i;
  logic [AW-1:0] wb_rd_addr_i;
  logic [DW-1:0] wb_rd_data_i;
  logic          alu_valid_o;
  logic          alu_ready_i;
  logic [DW-1:0] rs1_data_o;
  logic [DW-1:0] rs2_data_o;
  logic [FW-1:0] func_o;
  logic [AW-1:0] rd_addr_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  alu_operand_stage #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(AW),
    .FUNC_WIDTH    (FW)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .flush_i       (flush_i),
    .dec_valid_i   (dec_valid_i),
    .dec_ready_o   (dec_ready_o),
    .dec_func_i    (dec_func_i),
    .dec_rs1_addr_i(dec_rs1_addr_i),
    .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_rs1_data_i(dec_rs1_data_i),
    .dec_rs2_data_i(dec_rs2_data_i),
    .dec_rd_addr_i (dec_rd_addr_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_rd_data_i  (wb_rd_data_i),
    .alu_valid_o   (alu_valid_o),
    .alu_ready_i   (alu_ready_i),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .func_o        (func_o),
    .rd_addr_o     (rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // A bundle is consumed at the next rising edge whenever valid & ready is seen mid-cycle.
  always @(negedge clk) begin
    if (!arst && alu_valid_o && alu_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle: got func 0x%04h expected none at %0t", func_o, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_func", 32'(func_o), 32'(e.func));
        check("sb_rs1", rs1_data_o, e.rs1);
        check("sb_rs2", rs2_data_o, e.rs2);
        check("sb_rd", 32'(rd_addr_o), 32'(e.rd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [FW-1:0] f, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2, input logic [AW-1:0] rd);
    dec_valid_i    = 1'b1;
    dec_func_i     = f;
    dec_rs1_addr_i = a1;
    dec_rs1_data_i = d1;
    dec_rs2_addr_i = a2;
    dec_rs2_data_i = d2;
    dec_rd_addr_i  = rd;
  endtask

  // Waits (bounded) for space, presents the bundle for one edge and records the expectation.
  task automatic push_one(input logic [FW-1:0] f, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d1, input logic [AW-1:0] a2,
                          input logic [DW-1:0] d2, input logic [AW-1:0] rd,
                          input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    int   budget = 20;
    while (!dec_ready_o && budget > 0) begin
      step();
      budget--;
    end
    if (!dec_ready_o) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got ready 0 expected 1 at %0t", $time);
    end
    drive(f, a1, d1, a2, d2, rd);
    e.func = f;
    e.rs1  = e1;
    e.rs2  = e2;
    e.rd   = rd;
    sb_q.push_back(e);
    step();
  endtask

  task automatic idle();
    dec_valid_i = 1'b0;
    wb_valid_i  = 1'b0;
  endtask

  task automatic check_empty(input string name);
    check({name, "_valid"}, 32'(alu_valid_o), 32'd0);
    check({name, "_ready"}, 32'(dec_ready_o), 32'd1);
    check({name, "_rs1"}, rs1_data_o, 32'd0);
    check({name, "_rs2"}, rs2_data_o, 32'd0);
    check({name, "_func"}, 32'(func_o), 32'd0);
    check({name, "_rd"}, 32'(rd_addr_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    flush_i = 1'b0;
    alu_ready_i = 1'b1;
    wb_valid_i = 1'b0;
    wb_rd_addr_i = '0;
    wb_rd_data_i = '0;
    drive(16'h0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0);
    dec_valid_i = 1'b0;
    #12;
    check_empty("reset");
    step();
    arst = 1'b0;
    step();

    // Single issue
    push_one(SLL, 5'd1, 32'h0000_00F0, 5'd2, 32'h4, 5'd3, 32'h0000_00F0, 32'h4);
    idle();
    check("single_valid", 32'(alu_valid_o), 32'd1);
    check("single_rs1", rs1_data_o, 32'h0000_00F0);
    check("single_func", 32'(func_o), 32'(SLL));
    step();
    check_empty("single_after");

    // Backpressure: A, B buffered, C held upstream until ready returns
    alu_ready_i = 1'b0;
    push_one(SLL, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd10, 32'hA1, 32'hA2);
    push_one(SLLI, 5'd1, 32'hB1, 5'd2, 32'hB2, 5'd11, 32'hB1, 32'hB2);
    check("bp_ready_low", 32'(dec_ready_o), 32'd0);
    drive(SRL, 5'd1, 32'hC1, 5'd2, 32'hC2, 5'd12);
    step();
    check("bp_hold_ready", 32'(dec_ready_o), 32'd0);
    check("bp_hold_head", rs1_data_o, 32'hA1);
    begin
      exp_t e;
      e.func = SRL; e.rs1 = 32'hC1; e.rs2 = 32'hC2; e.rd = 5'd12;
      sb_q.push_back(e);
    end
    alu_ready_i = 1'b1;
    step();
    check("bp_head_b", 32'(rd_addr_o), 32'd11);
    step();
    idle();
    check("bp_head_c", 32'(rd_addr_o), 32'd12);
    step();
    check("bp_drained", 32'(alu_valid_o), 32'd0);

    // Streaming with pointer wrap: one bundle per cycle
    for (int k = 0; k < 5; k++) begin
      push_one(SLLI, 5'd4, 32'(k), 5'd6, 32'(k + 100), 5'(k + 1), 32'(k), 32'(k + 100));
    end
    idle();
    step();

    // Capture forwarding
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'hDEAD_BEEF;
    push_one(SLL, 5'd5, 32'h1, 5'd9, 32'h2, 5'd4, 32'hDEAD_BEEF, 32'h2);
    idle();
    check("fwd_rs1", rs1_data_o, 32'hDEAD_BEEF);
    step();
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd0; wb_rd_data_i = 32'hDEAD_BEEF;
    push_one(SLL, 5'd0, 32'h1, 5'd0, 32'h0, 5'd4, 32'h1, 32'h0);
    idle();
    check("fwd_x0_rs1", rs1_data_o, 32'h1);
    step();

    // Snoop while stalled
    alu_ready_i = 1'b0;
    push_one(SRL, 5'd8, 32'h33, 5'd7, 32'h10, 5'd6, 32'h33, 32'h20);
    idle();
    check("snoop_before", rs2_data_o, 32'h10);
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd7; wb_rd_data_i = 32'h20;
    step();
    wb_valid_i = 1'b0;
    check("snoop_rs2", rs2_data_o, 32'h20);
    check("snoop_rs1", rs1_data_o, 32'h33);
    check("snoop_func", 32'(func_o), 32'(SRL));
    check("snoop_rd", 32'(rd_addr_o), 32'd6);
    alu_ready_i = 1'b1;
    step();
    check("snoop_drained", 32'(alu_valid_o), 32'd0);

    // Flush at FULL with a push attempt, then at ONE with a push that must be discarded
    alu_ready_i = 1'b0;
    push_one(SLL, 5'd1, 32'h51, 5'd2, 32'h52, 5'd13, 32'h51, 32'h52);
    push_one(SLL, 5'd1, 32'h61, 5'd2, 32'h62, 5'd14, 32'h61, 32'h62);
    drive(SLLI, 5'd1, 32'h71, 5'd2, 32'h72, 5'd15);
    flush_i = 1'b1;
    sb_q.delete();
    step();
    flush_i = 1'b0;
    idle();
    check_empty("flush_full");
    push_one(SLL, 5'd1, 32'h81, 5'd2, 32'h82, 5'd16, 32'h81, 32'h82);
    sb_q.delete();
    drive(SLLI, 5'd1, 32'h91, 5'd2, 32'h92, 5'd17);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    idle();
    check_empty("flush_one");
    alu_ready_i = 1'b1;
    push_one(SRL, 5'd3, 32'hA5, 5'd4, 32'h5A, 5'd18, 32'hA5, 32'h5A);
    idle();
    check("flush_alone_rd", 32'(rd_addr_o), 32'd18);
    step();
    check("flush_alone_after", 32'(alu_valid_o), 32'd0);

    // Reset mid-stream with two entries buffered
    alu_ready_i = 1'b0;
    push_one(SLL, 5'd1, 32'hE1, 5'd2, 32'hE2, 5'd20, 32'hE1, 32'hE2);
    push_one(SLL, 5'd1, 32'hF1, 5'd2, 32'hF2, 5'd21, 32'hF1, 32'hF2);
    idle();
    check("pre_reset_valid", 32'(alu_valid_o), 32'd1);
    arst = 1'b1;
    #1;
    check_empty("midreset");
    sb_q.delete();
    #4;
    arst = 1'b0;
    alu_ready_i = 1'b1;
    step();
    check("post_reset_valid", 32'(alu_valid_o), 32'd0);

    // Let the scoreboard drain (bounded)
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
